// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM device-side responder: command encodings, error
// codes, init states, mode-register fields and the read-pipeline beat.
package sdram_pkg;

    // Values equal {RAS_N, CAS_N, WE_N} with CS_N=0 in the MSB.
    typedef enum logic [3:0] {
        CMD_LMR = 4'b0000,
        CMD_REF = 4'b0001,
        CMD_PRE = 4'b0010,
        CMD_ACT = 4'b0011,
        CMD_WR  = 4'b0100,
        CMD_RD  = 4'b0101,
        CMD_BST = 4'b0110,
        CMD_NOP = 4'b0111
    } cmd_e;

    typedef enum logic [3:0] {
        ERR_NONE,
        ERR_NO_INIT,
        ERR_MODE,
        ERR_BANK_OPEN,
        ERR_BANK_CLOSED,
        ERR_TRCD,
        ERR_TRP,
        ERR_TRFC,
        ERR_REFRESH_OPEN
    } err_e;

    typedef enum logic [1:0] {
        INIT_PRE,
        INIT_REF,
        INIT_MODE,
        INIT_READY
    } init_e;

    localparam int MODE_BL_LSB = 0;
    localparam int MODE_BL_MSB = 2;
    localparam int MODE_CL_LSB = 4;
    localparam int MODE_CL_MSB = 6;
    localparam int ADDR_AP_BIT = 10;

    typedef struct packed {
        logic        vld;
        logic [1:0]  msk;
        logic [15:0] dat;
    } rd_beat_t;

    function automatic cmd_e decode_cmd(input logic cke, input logic cs_n,
                                        input logic ras_n, input logic cas_n,
                                        input logic we_n);
        if (!cke || cs_n) return CMD_NOP;
        return cmd_e'({1'b0, ras_n, cas_n, we_n});
    endfunction

    // Only burst length 1 with CAS latency 2 or 3 is modelled.
    function automatic logic mode_ok(input logic [2:0] bl, input logic [2:0] cl);
        return (bl == 3'd0) && ((cl == 3'd2) || (cl == 3'd3));
    endfunction

endpackage

// File: rtl/sdram_resp_bank.sv
// One SDRAM bank: open flag, open row and the tRCD/tRP countdowns that gate
// the next READ/WRITE or ACTIVE to this bank.
module sdram_resp_bank #(
    parameter int T_RCD = 2,
    parameter int T_RP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       act_i,
    input  logic       pre_i,
    input  logic [1:0] row_i,
    output logic       open_o,
    output logic [1:0] row_o,
    output logic       trcd_busy_o,
    output logic       trp_busy_o
);

    localparam int TMAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CW   = $clog2(TMAX + 1);

    logic          open_q;
    logic [1:0]    row_q;
    logic [CW-1:0] trcd_q, trp_q;

    // Counters load T-1 at the command edge, so a command exactly T cycles
    // later sees zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q <= 1'b0;
            row_q  <= '0;
            trcd_q <= '0;
            trp_q  <= '0;
        end else begin
            if (act_i) begin
                open_q <= 1'b1;
                row_q  <= row_i;
            end else if (pre_i) begin
                open_q <= 1'b0;
            end

            if (act_i)              trcd_q <= CW'(T_RCD - 1);
            else if (trcd_q != '0)  trcd_q <= trcd_q - 1'b1;

            if (pre_i)              trp_q <= CW'(T_RP - 1);
            else if (trp_q != '0)   trp_q <= trp_q - 1'b1;
        end
    end

    assign open_o      = open_q;
    assign row_o       = row_q;
    assign trcd_busy_o = (trcd_q != '0);
    assign trp_busy_o  = (trp_q != '0);

endmodule

// File: rtl/sdram_responder.sv
// Device-side SDRAM model: decodes controller commands, checks init/timing
// rules, stores writes in a small array and returns reads after CL cycles.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int MEM_AW = 8,
    parameter int T_RCD  = 2,
    parameter int T_RP   = 2,
    parameter int T_RFC  = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] DRAM_ADDR,
    input  logic [1:0]  DRAM_BA,
    inout  wire  [15:0] DRAM_DQ,
    input  logic        DRAM_LDQM,
    input  logic        DRAM_UDQM,
    input  logic        DRAM_CS_N,
    input  logic        DRAM_RAS_N,
    input  logic        DRAM_CAS_N,
    input  logic        DRAM_WE_N,
    input  logic        DRAM_CKE,
    output logic        init_done,
    output logic [1:0]  cas_latency,
    output logic        cmd_err,
    output logic [3:0]  err_code
);

    localparam int RFC_W = $clog2(T_RFC + 1);

    cmd_e              cmd;
    err_e              err_d;
    logic              cmd_ok;
    logic              act_v, pre_v, rd_v, wr_v;
    logic [3:0]        bank_open, trcd_busy, trp_busy;
    logic [3:0][1:0]   bank_row;
    logic [MEM_AW-1:0] idx;

    init_e             init_q;
    logic              ref_cnt_q;
    logic [RFC_W-1:0]  trfc_q;
    logic [1:0]        cl_q;
    logic              init_done_q, cmd_err_q;
    err_e              err_code_q;

    logic [15:0]       mem_q [2**MEM_AW];
    rd_beat_t          new_beat, s0_d, s1_d, s0_q, s1_q, out_q;
    logic              wr_now;
    logic [1:0]        oe;

    logic              unused_addr;
    assign unused_addr = ^{DRAM_ADDR[12:11], DRAM_ADDR[9:7]};

    assign cmd = decode_cmd(DRAM_CKE, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N);

    // tRFC outranks everything; DESELECT and CKE-low already decode to NOP.
    always_comb begin
        err_d = ERR_NONE;
        if (cmd != CMD_NOP) begin
            if (trfc_q != '0) begin
                err_d = ERR_TRFC;
            end else begin
                case (cmd)
                    CMD_ACT: begin
                        if (init_q != INIT_READY)     err_d = ERR_NO_INIT;
                        else if (bank_open[DRAM_BA])  err_d = ERR_BANK_OPEN;
                        else if (trp_busy[DRAM_BA])   err_d = ERR_TRP;
                    end
                    CMD_RD, CMD_WR: begin
                        if (init_q != INIT_READY)     err_d = ERR_NO_INIT;
                        else if (!bank_open[DRAM_BA]) err_d = ERR_BANK_CLOSED;
                        else if (trcd_busy[DRAM_BA])  err_d = ERR_TRCD;
                    end
                    CMD_REF: if (|bank_open) err_d = ERR_REFRESH_OPEN;
                    CMD_LMR: begin
                        if (!mode_ok(DRAM_ADDR[MODE_BL_MSB:MODE_BL_LSB],
                                     DRAM_ADDR[MODE_CL_MSB:MODE_CL_LSB]))
                            err_d = ERR_MODE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_ok = (err_d == ERR_NONE);
    assign act_v  = cmd_ok && (cmd == CMD_ACT);
    assign pre_v  = cmd_ok && (cmd == CMD_PRE);
    assign rd_v   = cmd_ok && (cmd == CMD_RD);
    assign wr_v   = cmd_ok && (cmd == CMD_WR);

    for (genvar b = 0; b < 4; b++) begin : g_bank
        sdram_resp_bank #(
            .T_RCD (T_RCD),
            .T_RP  (T_RP)
        ) u_bank (
            .clk         (clk),
            .rst         (rst),
            .act_i       (act_v && (DRAM_BA == 2'(b))),
            .pre_i       (pre_v && (DRAM_ADDR[ADDR_AP_BIT] || (DRAM_BA == 2'(b)))),
            .row_i       (DRAM_ADDR[1:0]),
            .open_o      (bank_open[b]),
            .row_o       (bank_row[b]),
            .trcd_busy_o (trcd_busy[b]),
            .trp_busy_o  (trp_busy[b])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q      <= INIT_PRE;
            ref_cnt_q   <= 1'b0;
            trfc_q      <= '0;
            cl_q        <= 2'd0;
            init_done_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            if (trfc_q != '0) trfc_q <= trfc_q - 1'b1;
            if (!cmd_ok) begin
                if (!cmd_err_q) begin
                    cmd_err_q  <= 1'b1;
                    err_code_q <= err_d;
                end
            end else begin
                case (cmd)
                    CMD_PRE: begin
                        if (init_q == INIT_PRE && DRAM_ADDR[ADDR_AP_BIT]) init_q <= INIT_REF;
                    end
                    CMD_REF: begin
                        trfc_q <= RFC_W'(T_RFC - 1);
                        if (init_q == INIT_REF) begin
                            if (ref_cnt_q) init_q <= INIT_MODE;
                            ref_cnt_q <= ~ref_cnt_q;
                        end
                    end
                    CMD_LMR: begin
                        cl_q <= DRAM_ADDR[MODE_CL_LSB +: 2];
                        if (init_q == INIT_MODE) begin
                            init_q      <= INIT_READY;
                            init_done_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage is deliberately not reset: contents survive rst.
    assign idx = {DRAM_BA, bank_row[DRAM_BA], DRAM_ADDR[MEM_AW-5:0]};

    always_ff @(posedge clk) begin
        if (wr_v) begin
            if (!DRAM_LDQM) mem_q[idx][7:0]  <= DRAM_DQ[7:0];
            if (!DRAM_UDQM) mem_q[idx][15:8] <= DRAM_DQ[15:8];
        end
    end

    // CL=3 enters at s0, CL=2 skips straight to s1; out is driven for one cycle.
    always_comb begin
        new_beat = '{vld: rd_v, msk: {DRAM_UDQM, DRAM_LDQM}, dat: mem_q[idx]};
        s0_d     = '0;
        s1_d     = s0_q;
        if (rd_v && cl_q == 2'd3) s0_d = new_beat;
        else if (rd_v)            s1_d = new_beat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q  <= '0;
            s1_q  <= '0;
            out_q <= '0;
        end else begin
            s0_q  <= s0_d;
            s1_q  <= s1_d;
            out_q <= s1_q;
        end
    end

    // A WRITE on the pins means the controller owns DQ this cycle.
    assign wr_now = (cmd == CMD_WR);
    assign oe     = {2{out_q.vld & ~wr_now}} & ~out_q.msk;

    assign DRAM_DQ[7:0]  = oe[0] ? out_q.dat[7:0]  : 8'hzz;
    assign DRAM_DQ[15:8] = oe[1] ? out_q.dat[15:8] : 8'hzz;

    assign init_done   = init_done_q;
    assign cas_latency = cl_q;
    assign cmd_err     = cmd_err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init, table-driven write/read traffic,
// CL3, error latching and reset during an in-flight read.
module tb_sdram_responder;
    import sdram_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] DRAM_ADDR = '0;
    logic [1:0]  DRAM_BA = '0;
    wire  [15:0] DRAM_DQ;
    logic        DRAM_LDQM = 1'b0, DRAM_UDQM = 1'b0;
    logic        DRAM_CS_N = 1'b1, DRAM_RAS_N = 1'b1, DRAM_CAS_N = 1'b1, DRAM_WE_N = 1'b1;
    logic        DRAM_CKE = 1'b1;
    logic        init_done, cmd_err;
    logic [1:0]  cas_latency;
    logic [3:0]  err_code;
    logic [15:0] tb_dq = '0;
    logic        tb_dq_oe = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    // Released bus reads back as all ones.
    assign DRAM_DQ = tb_dq_oe ? tb_dq : 16'hzzzz;
    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup (DRAM_DQ[i]);
    end

    sdram_responder dut (
        .clk(clk), .rst(rst), .DRAM_ADDR(DRAM_ADDR), .DRAM_BA(DRAM_BA), .DRAM_DQ(DRAM_DQ),
        .DRAM_LDQM(DRAM_LDQM), .DRAM_UDQM(DRAM_UDQM), .DRAM_CS_N(DRAM_CS_N),
        .DRAM_RAS_N(DRAM_RAS_N), .DRAM_CAS_N(DRAM_CAS_N), .DRAM_WE_N(DRAM_WE_N),
        .DRAM_CKE(DRAM_CKE), .init_done(init_done), .cas_latency(cas_latency),
        .cmd_err(cmd_err), .err_code(err_code)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  ba;
        logic [12:0] col;
        logic [15:0] dat;
        logic [1:0]  dqm;   // {UDQM, LDQM}
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [15:0] d, input logic [1:0] m);
        {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = c;
        DRAM_BA = ba;
        DRAM_ADDR = a;
        {DRAM_UDQM, DRAM_LDQM} = m;
        tb_dq = d;
        tb_dq_oe = (c == CMD_WR);
    endtask

    task automatic idle();
        {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = CMD_NOP;
        {DRAM_UDQM, DRAM_LDQM} = 2'b00;
        tb_dq_oe = 1'b0;
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                         input logic [15:0] d = 16'h0, input logic [1:0] m = 2'b00);
        drive(c, ba, a, d, m);
        @(posedge clk); #1;
        idle();
    endtask

    task automatic nop(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // PRE-all, two refreshes exactly tRFC apart, then LOAD MODE exactly tRFC later.
    task automatic init_seq(input logic [12:0] mode);
        issue(CMD_PRE, 2'd0, 13'h400);
        nop(1);
        issue(CMD_REF, 2'd0, 13'h0);
        nop(6);
        issue(CMD_REF, 2'd0, 13'h0);
        nop(6);
        issue(CMD_LMR, 2'd0, mode);
        nop(1);
    endtask

    // After the READ edge n, data is expected only in the window n+cl-1..n+cl.
    task automatic read_chk(input string name, input logic [1:0] ba, input logic [12:0] col,
                            input logic [15:0] exp, input int cl);
        issue(CMD_RD, ba, col);
        for (int k = 1; k <= cl; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_k%0d", name, k), DRAM_DQ, (k == cl - 1) ? exp : 16'hFFFF);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'd0, 13'h003, 16'hAAAA, 2'b00, 16'h0000};
        vecs[1]  = '{1'b1, 2'd1, 13'h003, 16'h5555, 2'b00, 16'h0000};
        vecs[2]  = '{1'b1, 2'd2, 13'h00F, 16'h1234, 2'b00, 16'h0000};
        vecs[3]  = '{1'b1, 2'd2, 13'h00F, 16'hFFFF, 2'b10, 16'h0000};
        vecs[4]  = '{1'b1, 2'd3, 13'h013, 16'h0F0F, 2'b00, 16'h0000};
        vecs[5]  = '{1'b1, 2'd3, 13'h003, 16'hC3C3, 2'b01, 16'h0000};
        vecs[6]  = '{1'b0, 2'd0, 13'h003, 16'h0000, 2'b00, 16'hAAAA};
        vecs[7]  = '{1'b0, 2'd1, 13'h003, 16'h0000, 2'b00, 16'h5555};
        vecs[8]  = '{1'b0, 2'd2, 13'h00F, 16'h0000, 2'b00, 16'h12FF};
        vecs[9]  = '{1'b0, 2'd3, 13'h003, 16'h0000, 2'b00, 16'hC30F};
        vecs[10] = '{1'b0, 2'd3, 13'h023, 16'h0000, 2'b00, 16'hC30F};

        do_reset();
        chk("rst_init_done", {15'd0, init_done}, 16'd0);
        chk("rst_cl", {14'd0, cas_latency}, 16'd0);
        chk("rst_cmd_err", {15'd0, cmd_err}, 16'd0);
        chk("rst_err_code", {12'd0, err_code}, 16'(ERR_NONE));
        chk("rst_dq", DRAM_DQ, 16'hFFFF);

        // CL2 traffic over all four banks
        init_seq(13'h020);
        chk("cl2_init_done", {15'd0, init_done}, 16'd1);
        chk("cl2_cl", {14'd0, cas_latency}, 16'd2);
        for (int b = 0; b < 4; b++) issue(CMD_ACT, 2'(b), 13'(b));
        nop(1);
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) issue(CMD_WR, vecs[i].ba, vecs[i].col, vecs[i].dat, vecs[i].dqm);
            else read_chk($sformatf("vec%0d", i), vecs[i].ba, vecs[i].col, vecs[i].exp, 2);
        end

        // back-to-back reads
        issue(CMD_RD, 2'd0, 13'h003);
        issue(CMD_RD, 2'd1, 13'h003);
        chk("b2b_first", DRAM_DQ, 16'hAAAA);
        @(posedge clk); #1;
        chk("b2b_second", DRAM_DQ, 16'h5555);
        @(posedge clk); #1;
        chk("b2b_release", DRAM_DQ, 16'hFFFF);

        // WRITE on the pins while read data is due: device must back off
        issue(CMD_RD, 2'd0, 13'h003);
        @(posedge clk); #1;
        drive(CMD_WR, 2'd1, 13'h005, 16'h7777, 2'b00);
        #2 chk("turnaround_dq", DRAM_DQ, 16'h7777);
        @(posedge clk); #1;
        idle();
        read_chk("turnaround_rd", 2'd1, 13'h005, 16'h7777, 2);
        chk("cl2_no_err", {15'd0, cmd_err}, 16'd0);

        // READ to a closed bank, then legal traffic at exactly tRCD
        do_reset();
        init_seq(13'h020);
        issue(CMD_RD, 2'd1, 13'h003);
        chk("closed_err", {15'd0, cmd_err}, 16'd1);
        chk("closed_code", {12'd0, err_code}, 16'(ERR_BANK_CLOSED));
        issue(CMD_ACT, 2'd0, 13'h000);
        nop(1);
        issue(CMD_WR, 2'd0, 13'h002, 16'h3C3C);
        read_chk("after_err", 2'd0, 13'h002, 16'h3C3C, 2);
        issue(CMD_ACT, 2'd0, 13'h000);
        chk("sticky_code", {12'd0, err_code}, 16'(ERR_BANK_CLOSED));

        do_reset();
        init_seq(13'h020);
        issue(CMD_ACT, 2'd0, 13'h000);
        issue(CMD_RD, 2'd0, 13'h003);
        chk("trcd_code", {12'd0, err_code}, 16'(ERR_TRCD));

        do_reset();
        issue(CMD_PRE, 2'd0, 13'h400);
        nop(1);
        issue(CMD_REF, 2'd0, 13'h0);
        nop(6);
        issue(CMD_REF, 2'd0, 13'h0);
        nop(6);
        issue(CMD_ACT, 2'd2, 13'h000);
        chk("noinit_code", {12'd0, err_code}, 16'(ERR_NO_INIT));
        chk("noinit_done", {15'd0, init_done}, 16'd0);

        do_reset();
        issue(CMD_PRE, 2'd0, 13'h400);
        nop(1);
        issue(CMD_REF, 2'd0, 13'h0);
        nop(6);
        issue(CMD_REF, 2'd0, 13'h0);
        nop(6);
        issue(CMD_LMR, 2'd0, 13'h050);
        chk("mode_code", {12'd0, err_code}, 16'(ERR_MODE));
        chk("mode_cl", {14'd0, cas_latency}, 16'd0);
        chk("mode_done", {15'd0, init_done}, 16'd0);

        // second refresh one cycle inside tRFC
        do_reset();
        issue(CMD_PRE, 2'd0, 13'h400);
        nop(1);
        issue(CMD_REF, 2'd0, 13'h0);
        nop(5);
        issue(CMD_REF, 2'd0, 13'h0);
        chk("trfc_code", {12'd0, err_code}, 16'(ERR_TRFC));

        do_reset();
        init_seq(13'h020);
        issue(CMD_ACT, 2'd0, 13'h000);
        nop(1);
        issue(CMD_PRE, 2'd0, 13'h000);
        issue(CMD_ACT, 2'd0, 13'h000);
        chk("trp_code", {12'd0, err_code}, 16'(ERR_TRP));

        do_reset();
        init_seq(13'h020);
        issue(CMD_ACT, 2'd0, 13'h000);
        nop(3);
        issue(CMD_REF, 2'd0, 13'h0);
        chk("refopen_code", {12'd0, err_code}, 16'(ERR_REFRESH_OPEN));

        // CL3; a READ with CKE low is ignored
        do_reset();
        init_seq(13'h030);
        chk("cl3_cl", {14'd0, cas_latency}, 16'd3);
        issue(CMD_ACT, 2'd0, 13'h000);
        nop(1);
        issue(CMD_WR, 2'd0, 13'h003, 16'hAAAA);
        read_chk("cl3_rd", 2'd0, 13'h003, 16'hAAAA, 3);
        DRAM_CKE = 1'b0;
        issue(CMD_RD, 2'd2, 13'h000);
        DRAM_CKE = 1'b1;
        chk("cke_low_no_err", {15'd0, cmd_err}, 16'd0);

        // reset while read data is on the bus
        do_reset();
        init_seq(13'h020);
        issue(CMD_ACT, 2'd0, 13'h000);
        nop(1);
        issue(CMD_WR, 2'd0, 13'h003, 16'h5A5A);
        issue(CMD_RD, 2'd0, 13'h003);
        @(posedge clk); #1;
        chk("midrd_data", DRAM_DQ, 16'h5A5A);
        rst = 1'b1;
        #1;
        chk("midrd_dq", DRAM_DQ, 16'hFFFF);
        chk("midrd_done", {15'd0, init_done}, 16'd0);
        chk("midrd_cl", {14'd0, cas_latency}, 16'd0);
        chk("midrd_err", {15'd0, cmd_err}, 16'd0);
        chk("midrd_code", {12'd0, err_code}, 16'(ERR_NONE));
        @(posedge clk); #3 rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
